// File: rtl/mips32_mem_pkg.sv
// Shared constants and FSM state type for the MIPS32 data-memory responder.
package mips32_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEPTH_DEF       = 256;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mips32_dmem_array.sv
// Single-port synchronous DEPTH x 32 data storage; contents are never reset.
module mips32_dmem_array
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Write on enabled store; otherwise capture the read word.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_dmem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES wait states per access.
// Optional macro DMEM_ERR_EN: out-of-range addresses flag rsp_err instead of wrapping.
module mips32_dmem_responder
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;

  logic              accept_s, enter_s, cur_we_s, range_err_s, err_s;
  logic [WORD_W-1:0] cur_addr_s, cur_wdata_s, arr_rdata_s;
  logic              unused_addr_s;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept_s  = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, so use live request fields.
  assign cur_we_s    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr_s  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata_s = (state_q == IDLE) ? req_wdata : wdata_q;
  assign enter_s     = (state_d == RESP) && (state_q != RESP);
  assign unused_addr_s = ^cur_addr_s[WORD_W-1:AW];

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and request-capture registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

`ifdef DMEM_ERR_EN
  logic err_q;

  assign range_err_s = (cur_addr_s >= WORD_W'(DEPTH));

  // Error flag is captured on RESP entry and held for the whole response.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (enter_s) begin
      err_q <= range_err_s;
    end
  end

  assign err_s   = err_q && (state_q == RESP);
  assign rsp_err = err_s;
`else
  assign range_err_s = 1'b0;
  assign err_s       = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  mips32_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk1),
    .en_i    (enter_s),
    .we_i    (cur_we_s && !range_err_s),
    .addr_i  (cur_addr_s[AW-1:0]),
    .wdata_i (cur_wdata_s),
    .rdata_o (arr_rdata_s)
  );

  assign rsp_rdata = ((state_q == RESP) && !we_q && !err_s) ? arr_rdata_s : '0;

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Randomized bench for mips32_dmem_responder against a word-array reference model.
module tb_mips32_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_ok  [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  mips32_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mips32_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk1(clk1), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return a >= 32'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // Expected response for a request given the current model contents.
  task automatic model_expect(input bit we, input logic [31:0] addr,
                              output logic [31:0] exp_d, output bit chk_d, output bit bad);
    int idx;
    bad   = addr_bad(addr);
    idx   = int'(addr % 32'(DEPTH));
    exp_d = 32'd0;
    chk_d = 1'b1;
    if (!we && !bad) begin
      if (ref_ok[idx]) exp_d = ref_mem[idx];
      else chk_d = 1'b0;
    end
  endtask

  task automatic model_commit(input bit we, input logic [31:0] addr, input logic [31:0] data);
    int idx;
    idx = int'(addr % 32'(DEPTH));
    if (we && !addr_bad(addr)) begin
      ref_mem[idx] = data;
      ref_ok[idx]  = 1'b1;
    end
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // rst_mode: 0 none, 1 reset while waiting, 2 reset while responding
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input int hold, input int rst_mode);
    logic [31:0] exp_d, d0;
    bit          chk_d, bad;
    int          k;
    model_expect(we, addr, exp_d, chk_d, bad);
    @(negedge clk1);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    @(negedge clk1);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    k = 1;
    if (rst_mode == 1) begin
      chk("wait_ready", 32'(req_ready), 32'd0);
      reset_pulse();
      return;
    end
    while (!rsp_valid && k < 40) begin
      chk("busy_ready", 32'(req_ready), 32'd0);
      @(negedge clk1);
      k++;
    end
    chk("latency", 32'(k), 32'(W + 1));
    model_commit(we, addr, data);
    if (rst_mode == 2) begin
      reset_pulse();
      return;
    end
    chk("rsp_err", 32'(rsp_err), 32'(bad));
    if (chk_d) chk("rsp_rdata", rsp_rdata, exp_d);
    d0 = rsp_rdata;
    repeat (hold) begin
      @(negedge clk1);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, d0);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk1);
    rsp_ready = 1'b0;
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_rdata", rsp_rdata, 32'd0);
  endtask

  // Four requests with req_valid held high and rsp_ready always 1.
  task automatic back_to_back();
    bit          we_a [4];
    logic [31:0] ad_a [4], dt_a [4];
    int          acc_c [4];
    logic [31:0] exp_q [$];
    bit          chk_q [$], bad_q [$];
    logic [31:0] e;
    bit          c, b;
    int          n, got, cyc;
    ad_a[0] = 32'($urandom_range(16, 255)); ad_a[1] = ad_a[0];
    ad_a[2] = 32'($urandom_range(16, 255)); ad_a[3] = ad_a[2];
    we_a[0] = 1'b1; we_a[1] = 1'b0; we_a[2] = 1'b1; we_a[3] = 1'b0;
    for (int i = 0; i < 4; i++) dt_a[i] = $urandom;
    n = 0; got = 0; cyc = 0;
    @(negedge clk1);
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_we = we_a[0]; req_addr = ad_a[0]; req_wdata = dt_a[0];
    while ((n < 4 || got < 4) && cyc < 80) begin
      if (req_valid && req_ready) begin
        acc_c[n] = cyc;
        model_expect(we_a[n], ad_a[n], e, c, b);
        model_commit(we_a[n], ad_a[n], dt_a[n]);
        exp_q.push_back(e); chk_q.push_back(c); bad_q.push_back(b);
        n++;
      end
      if (rsp_valid && got < n) begin
        chk("b2b_latency", 32'(cyc - acc_c[got]), 32'(W + 1));
        e = exp_q.pop_front(); c = chk_q.pop_front(); b = bad_q.pop_front();
        if (c) chk("b2b_rdata", rsp_rdata, e);
        chk("b2b_err", 32'(rsp_err), 32'(b));
        got++;
      end
      @(negedge clk1);
      cyc++;
      if (n < 4) begin
        req_we = we_a[n]; req_addr = ad_a[n]; req_wdata = dt_a[n];
      end else begin
        req_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("b2b_accepts", 32'(n), 32'd4);
    chk("b2b_responses", 32'(got), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < n) chk("b2b_spacing", 32'(acc_c[i+1] - acc_c[i]), 32'(W + 2));
    end
  endtask

  // Single request on the zero-wait-state instance.
  task automatic b_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                       output int lat, output logic [31:0] rd);
    @(negedge clk1);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = data;
    @(negedge clk1);
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin
      @(negedge clk1);
      lat++;
    end
    rd = b_rsp_rdata;
    b_rsp_ready = 1'b1;
    @(negedge clk1);
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0; b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk1);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 32'd5, 32'h0000_00AA, 0, 0);
    do_req(1'b0, 32'd5, 32'd0, 0, 0);
    do_req(1'b0, 32'd5, 32'd0, 5, 0);

    do_req(1'b1, 32'd7, 32'h0000_0011, 0, 0);
    do_req(1'b1, 32'd7, 32'hDEAD_BEEF, 0, 1);
    do_req(1'b0, 32'd7, 32'd0, 0, 0);

    do_req(1'b1, 32'd9, 32'h0000_0099, 0, 0);
    do_req(1'b1, 32'd9, 32'hCAFE_0009, 0, 2);
    do_req(1'b0, 32'd9, 32'd0, 0, 0);

    do_req(1'b1, 32'd44, 32'h0000_0044, 0, 0);
    do_req(1'b1, 32'd300, 32'h0000_BEEF, 0, 0);
    do_req(1'b0, 32'd44, 32'd0, 0, 0);
    do_req(1'b0, 32'd300, 32'd0, 0, 0);

    back_to_back();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 600)) : 32'($urandom_range(0, 15));
      do_req(1'($urandom), a, $urandom, $urandom_range(0, 3), 0);
    end

    b_req(1'b1, 32'd0, 32'h0000_1234, lat, rd);
    chk("w0_store_latency", 32'(lat), 32'd1);
    chk("w0_store_rdata", rd, 32'd0);
    b_req(1'b0, 32'd0, 32'd0, lat, rd);
    chk("w0_load_latency", 32'(lat), 32'd1);
    chk("w0_load_rdata", rd, 32'h0000_1234);
    chk("w0_idle_ready", 32'(b_req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_dmem_responder.md
MIPS32_DMEM_RESPONDER -- requirements
Module: mips32_dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit data words stored (power of two, 2..1024).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between request accept and response (0..15).
REQ-003 clk1  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  requester presents a load/store.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  word address (same word addressing as the pipeline ALU output).
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores.
REQ-013 rsp_err  output  1  address-range error flag; tied 0 unless DMEM_ERR_EN is defined.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-016 A request SHALL be accepted on an edge where req_valid && req_ready; req_we, req_addr and req_wdata SHALL be latched on that edge.
REQ-017 On accept: WAIT_CYCLES > 0 -> WAIT with the wait counter loaded to WAIT_CYCLES-1; WAIT_CYCLES = 0 -> RESP directly.
REQ-018 In WAIT the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP on the next edge.
REQ-019 Latency: rsp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 The store write and load read SHALL both occur on the edge entering RESP; rsp_rdata SHALL hold the read value for the whole RESP state.
REQ-021 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL remain stable until rsp_valid && rsp_ready; on that edge the FSM SHALL return to IDLE.
REQ-022 Outside RESP, rsp_valid SHALL be 0, and rsp_rdata and rsp_err SHALL be 0.
REQ-023 Throughput: at most one request per WAIT_CYCLES+2 cycles; the next request cannot be accepted on the response handshake edge.
REQ-024 A load immediately following a store to the same address SHALL return the stored data.
REQ-025 req_valid dropping while req_ready=0 SHALL have no effect; inputs are sampled only on the accept edge.

Reset
REQ-026 On rst_n low: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset during WAIT SHALL abort the request, with no store write committed.
REQ-029 Reset during RESP SHALL drop the pending response; a write already committed on RESP entry SHALL remain.

Configuration
REQ-030 Macro DMEM_ERR_EN defined: a request with req_addr >= DEPTH SHALL complete with normal latency, rsp_err=1 and rsp_rdata=0, and a store to such an address SHALL NOT write.
REQ-031 Macro DMEM_ERR_EN undefined: the address SHALL be truncated to its low log2(DEPTH) bits (wrap-around), and rsp_err SHALL be constant 0.

Structure
REQ-032 Package mips32_mem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), the default DEPTH and WAIT_CYCLES constants, and the 32-bit word width constant.
REQ-033 Storage SHALL be a sub-module mips32_dmem_array (single-port synchronous, DEPTH x 32, write enable, no reset); FSM and counter SHALL live in the top module.

Verification
REQ-034 Store addr 5 data 32'h0000_00AA, then load addr 5 (WAIT_CYCLES=2) -> each rsp_valid arrives 3 cycles after accept; load rsp_rdata=32'h0000_00AA.
REQ-035 WAIT_CYCLES=0: load from a preloaded addr 0 = 32'h1234 -> rsp_valid 1 cycle after accept, rsp_rdata=32'h1234.
REQ-036 Hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; return to IDLE one edge after rsp_ready=1.
REQ-037 Assert rst_n=0 during WAIT of a store to addr 7 (old value 32'h11) -> outputs return to reset values; a later load of addr 7 returns 32'h11.
REQ-038 Store to addr 300 with DEPTH=256: DMEM_ERR_EN defined -> rsp_err=1 and addr 44 unchanged; DMEM_ERR_EN undefined -> addr 44 written, rsp_err=0.
REQ-039 Back-to-back req_valid held high for 4 requests -> accepts spaced exactly WAIT_CYCLES+2 cycles apart, with responses in order.
